// File: rtl/sflash_target.sv
// SPI/dual/quad flash-style target: synchronizes the SPI pins into clk, shifts bytes
// in and out per lane mode, and hands bytes to/from the core via a one-entry tx register.
module sflash_target #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [3:0] io_di,
  output logic [3:0] io_do,
  output logic [3:0] io_oe,
  input  logic [1:0] lanes,
  input  logic       dir,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sof,
  output logic       eof,
  output logic       underrun
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  typedef enum logic [1:0] {M_SINGLE = 2'b00, M_DUAL = 2'b01, M_QUAD = 2'b10} mode_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, settle_q;
  logic [3:0]             io_sync_q [SYNC_STAGES];

  logic       sclk_prev_q, cs_prev_q, armed_q, armed_d;
  mode_t      mode_q, mode_d, load_mode;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_nxt;
  logic [7:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic       hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d;

  logic       sclk_s, cs_s;
  logic [3:0] io_s;
  logic       sclk_rise, sclk_fall, start, stop, active_run, boundary, load, handshake;
  logic       byte_fresh, rx_en;

  function automatic logic [3:0] full_cnt(input mode_t m);
    case (m)
      M_DUAL:  return 4'd4;
      M_QUAD:  return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      settle_q    <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) io_sync_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      io_sync_q[0] <= io_di;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) io_sync_q[i] <= io_sync_q[i-1];
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign io_s   = io_sync_q[SYNC_STAGES-1];

  // sof needs cs_n seen high after the chain holds real samples, so a frame cut by reset stays dead
  assign armed_d    = armed_q | (settle_q[SYNC_STAGES-1] & cs_s);
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign start      = (state_q == ST_IDLE) & ~cs_s & cs_prev_q & armed_q;
  assign stop       = (state_q == ST_ACTIVE) & cs_s & ~cs_prev_q;
  assign active_run = (state_q == ST_ACTIVE) & ~stop;
  assign boundary   = active_run & sclk_fall & (cnt_q == 4'd0);
  assign load       = start | boundary;
  assign handshake  = tx_valid & ~hold_full_q;
  assign load_mode  = (lanes == 2'b11) ? M_SINGLE : mode_t'(lanes);
  assign byte_fresh = (cnt_q == full_cnt(mode_q));
  assign rx_en      = (mode_q == M_SINGLE) | ~dir;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACTIVE;
      ST_ACTIVE: if (stop)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (mode_q)
      M_DUAL:  rx_nxt = {rx_sh_q[5:0], io_s[1:0]};
      M_QUAD:  rx_nxt = {rx_sh_q[3:0], io_s};
      default: rx_nxt = {rx_sh_q[6:0], io_s[0]};
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    if (handshake) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (load) begin
      mode_d  = load_mode;
      cnt_d   = full_cnt(load_mode);
      rx_sh_d = '0;
      // a byte arriving in the same cycle as the load goes straight to the shifter
      if (hold_full_q) begin
        tx_sh_d     = hold_q;
        hold_full_d = 1'b0;
      end else if (handshake) begin
        tx_sh_d     = tx_data;
        hold_full_d = 1'b0;
      end else begin
        tx_sh_d    = '1;
        underrun_d = 1'b1;
      end
    end else if (active_run && sclk_rise && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (rx_en) begin
        rx_sh_d = rx_nxt;
        if (cnt_q == 4'd1) begin
          rx_data_d  = rx_nxt;
          rx_valid_d = 1'b1;
        end
      end
    end else if (active_run && sclk_fall && !byte_fresh) begin
      case (mode_q)
        M_DUAL:  tx_sh_d = {tx_sh_q[5:0], 2'b00};
        M_QUAD:  tx_sh_d = {tx_sh_q[3:0], 4'b0000};
        default: tx_sh_d = {tx_sh_q[6:0], 1'b0};
      endcase
    end
    if (stop) tx_sh_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      mode_q      <= M_SINGLE;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    io_do    = '0;
    io_oe    = '0;
    sof      = start;
    eof      = stop;
    tx_ready = ~hold_full_q;
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    underrun = underrun_q;
    if (state_q == ST_ACTIVE) begin
      case (mode_q)
        M_DUAL: begin
          io_do[1:0] = tx_sh_q[7:6];
          io_oe      = dir ? 4'b0011 : 4'b0000;
        end
        M_QUAD: begin
          io_do = tx_sh_q[7:4];
          io_oe = dir ? 4'b1111 : 4'b0000;
        end
        default: begin
          io_do[1] = tx_sh_q[7];
          io_oe    = 4'b0010;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sflash_target.sv
// Randomized bench for sflash_target: an SPI initiator drives frames while a byte-level
// model (expected tx stream, sent rx bytes, strobe counts) predicts what the target does.
module tb_sflash_target;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       cs_n = 1'b1;
  logic [3:0] io_di = '0;
  logic [3:0] io_do, io_oe;
  logic [1:0] lanes = '0;
  logic       dir = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, sof, eof, underrun;

  always #5 clk = ~clk;

  sflash_target #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .io_di(io_di),
    .io_do(io_do), .io_oe(io_oe), .lanes(lanes), .dir(dir),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .sof(sof), .eof(eof), .underrun(underrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [7:0] txq[$];
  logic [7:0] exp_txq[$];
  logic [7:0] send_bytes[$];
  logic [7:0] rxq[$];
  int sof_n, eof_n, und_n;

  always @(posedge clk) begin
    #1;
    if (sof)      sof_n++;
    if (eof)      eof_n++;
    if (underrun) und_n++;
    if (rx_valid) rxq.push_back(rx_data);
  end

  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      if (txq.size() > 0) begin
        tx_data  = txq[0];
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        @(posedge clk);
        if (txq.size() > 0) void'(txq.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_tx(input logic [7:0] b);
    txq.push_back(b);
    exp_txq.push_back(b);
  endtask

  function automatic logic [3:0] grp(input logic [7:0] b, input int unsigned eff, input int unsigned k);
    case (eff)
      0:       return {2'b00, b[7-k], 1'b0};
      1:       return {2'b00, b[7-2*k -: 2]};
      default: return b[7-4*k -: 4];
    endcase
  endfunction

  function automatic logic [3:0] din(input logic [7:0] b, input int unsigned eff, input int unsigned k);
    case (eff)
      0:       return {3'b000, b[7-k]};
      1:       return {2'b00, b[7-2*k -: 2]};
      default: return b[7-4*k -: 4];
    endcase
  endfunction

  function automatic logic [3:0] oe_exp(input int unsigned eff, input logic d);
    case (eff)
      0:       return 4'b0010;
      1:       return d ? 4'b0011 : 4'b0000;
      default: return d ? 4'b1111 : 4'b0000;
    endcase
  endfunction

  task automatic sclk_bit(input logic [3:0] v);
    sclk  = 1'b0;
    io_di = v;
    repeat (8) @(negedge clk);
    sclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // nrises_in = 0 runs whole bytes; otherwise cs_n rises after that many sclk rises
  task automatic run_frame(input logic [1:0] ln, input logic d, input int unsigned nbytes,
                           input int unsigned nrises_in);
    int unsigned eff, rpb, total, started, exp_und, bi, k, exp_rx;
    logic [7:0]  txe[$];
    logic [7:0]  rxs[$];
    logic [3:0]  oe_e;
    logic        rx_ok;
    eff     = (ln == 2'b11) ? 0 : int'(ln);
    rpb     = 8 >> eff;
    total   = (nrises_in == 0) ? nbytes * rpb : nrises_in;
    started = (total + rpb - 1) / rpb;
    exp_und = 0;
    while (send_bytes.size() < started) send_bytes.push_back(8'($urandom));
    for (int unsigned b = 0; b < started; b++) begin
      rxs.push_back(send_bytes.pop_front());
      if (exp_txq.size() > 0) txe.push_back(exp_txq.pop_front());
      else begin
        txe.push_back(8'hFF);
        exp_und++;
      end
    end
    send_bytes.delete();
    oe_e   = oe_exp(eff, d);
    rx_ok  = (eff == 0) || !d;
    exp_rx = rx_ok ? total / rpb : 0;

    repeat (4) @(negedge clk);
    sof_n = 0; eof_n = 0; und_n = 0; rxq.delete();
    lanes = ln; dir = d; cs_n = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1;
    chk("oe_at_start", io_oe, oe_e);
    if (oe_e != 4'b0000) chk("first_tx_bits", io_do & oe_e, grp(txe[0], eff, 0) & oe_e);
    repeat (6) @(negedge clk);
    for (int unsigned r = 0; r < total; r++) begin
      bi = r / rpb;
      k  = r % rpb;
      sclk  = 1'b0;
      io_di = din(rxs[bi], eff, k);
      repeat (8) @(negedge clk);
      chk("oe_active", io_oe, oe_e);
      if (oe_e != 4'b0000) chk("tx_group", io_do & oe_e, grp(txe[bi], eff, k) & oe_e);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
    chk("oe_after_eof", io_oe, 4'b0000);
    repeat (4) @(negedge clk);
    chk("sof_count", sof_n, 1);
    chk("eof_count", eof_n, 1);
    chk("underrun_count", und_n, exp_und);
    chk("rx_count", rxq.size(), exp_rx);
    for (int unsigned b = 0; b < exp_rx && b < rxq.size(); b++) chk("rx_byte", rxq[b], rxs[b]);
    chk("tx_ready_end", tx_ready, exp_txq.size() == 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_io_do"}, io_do, 4'b0000);
    chk({tag, "_io_oe"}, io_oe, 4'b0000);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_strobes"}, {rx_valid, sof, eof, underrun}, 4'b0000);
    chk({tag, "_tx_ready"}, tx_ready, 1'b1);
  endtask

  initial begin
    logic [1:0]  ln;
    logic        d;
    int unsigned nb, rpbv, nr, np;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single mode, A5 out, 3C in
    push_tx(8'hA5);
    send_bytes.push_back(8'h3C);
    run_frame(2'b00, 1'b0, 1, 0);

    // quad receive, two bytes, nothing to send
    send_bytes.push_back(8'h9E);
    send_bytes.push_back(8'h47);
    run_frame(2'b10, 1'b0, 2, 0);

    // quad transmit
    push_tx(8'hC3);
    push_tx(8'h5A);
    run_frame(2'b10, 1'b1, 2, 0);

    // single mode with no tx data
    run_frame(2'b00, 1'b0, 2, 0);

    // abort after 5 bits, then the retained holding byte leads the next frame
    push_tx(8'h11);
    push_tx(8'h22);
    run_frame(2'b00, 1'b0, 1, 5);
    run_frame(2'b00, 1'b0, 1, 0);

    for (int i = 0; i < 20; i++) begin
      ln   = 2'($urandom_range(3));
      d    = 1'($urandom_range(1));
      nb   = $urandom_range(1, 3);
      rpbv = 8 >> ((ln == 2'b11) ? 0 : int'(ln));
      nr   = ($urandom_range(3) == 0) ? $urandom_range(1, nb * rpbv - 1) : 0;
      np   = $urandom_range(0, nb + 1);
      for (int unsigned j = 0; j < np; j++) push_tx(8'($urandom));
      run_frame(ln, d, nb, nr);
    end

    // reset mid-byte with cs_n held low
    txq.delete();
    exp_txq.delete();
    repeat (4) @(negedge clk);
    lanes = 2'b00; dir = 1'b0; cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) sclk_bit(4'b0001);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midframe_rst");
    rst = 1'b0;
    sclk = 1'b1;
    sof_n = 0; eof_n = 0; und_n = 0; rxq.delete();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) sclk_bit(4'($urandom));
    chk("no_sof_after_rst", sof_n, 0);
    chk("no_eof_after_rst", eof_n, 0);
    chk("no_rx_after_rst", rxq.size(), 0);
    chk("idle_oe_after_rst", io_oe, 4'b0000);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_eof_in_idle", eof_n, 0);
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("sof_after_toggle", sof_n, 1);
    chk("oe_after_toggle", io_oe, 4'b0010);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("eof_after_toggle", eof_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
